// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 multiplier/divider taking WIDTH cycles per operation.
// Define MULDIV_DIV_EN to build the restoring divider; without it divides return err.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             start,
    input  logic             op_div,
    input  logic             sign_en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             err
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t             state, state_nx;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   m, p_hi, p_lo;
    logic               neg_q, fault_q;
    logic               accept, a_neg, b_neg, fault_in;
    logic [WIDTH-1:0]   a_mag, b_mag, m_in, hi_in, lo_in;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   step_hi, step_lo, res_hi, res_lo;
    logic [2*WIDTH-1:0] prod;

    assign accept = start && (state == IDLE || state == DONE);
    assign busy   = state == RUN || state == FIX;
    assign done   = state == DONE;
    assign a_neg  = sign_en && a[WIDTH-1];
    assign b_neg  = sign_en && b[WIDTH-1];
    assign a_mag  = a_neg ? -a : a;
    assign b_mag  = b_neg ? -b : b;
    assign sum    = {1'b0, p_hi} + (p_lo[0] ? {1'b0, m} : '0);
    assign prod   = neg_q ? -{p_hi, p_lo} : {p_hi, p_lo};

`ifdef MULDIV_DIV_EN
    logic           div_q, rneg_q, div0, fits;
    logic [WIDTH:0] shifted;

    // Divide-by-zero bypasses the iterations and parks a / all-ones for FIX to publish.
    assign div0     = op_div && b == '0;
    assign fault_in = div0;
    assign m_in     = op_div ? b_mag : a_mag;
    assign hi_in    = div0 ? a : '0;
    assign lo_in    = op_div ? (div0 ? '1 : a_mag) : b_mag;
    assign shifted  = {p_hi, p_lo[WIDTH-1]};
    assign fits     = shifted >= {1'b0, m};
    assign step_hi  = div_q ? (fits ? shifted[WIDTH-1:0] - m : shifted[WIDTH-1:0]) : sum[WIDTH:1];
    assign step_lo  = div_q ? {p_lo[WIDTH-2:0], fits} : {sum[0], p_lo[WIDTH-1:1]};
    assign res_hi   = fault_q ? p_hi : div_q ? (rneg_q ? -p_hi : p_hi) : prod[2*WIDTH-1:WIDTH];
    assign res_lo   = fault_q ? p_lo : div_q ? (neg_q ? -p_lo : p_lo) : prod[WIDTH-1:0];

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) {div_q, rneg_q} <= '0;
        else if (accept) {div_q, rneg_q} <= {op_div, a_neg};
    end
`else
    assign fault_in = op_div;
    assign m_in     = a_mag;
    assign hi_in    = '0;
    assign lo_in    = op_div ? '0 : b_mag;
    assign step_hi  = sum[WIDTH:1];
    assign step_lo  = {sum[0], p_lo[WIDTH-1:1]};
    assign res_hi   = fault_q ? p_hi : prod[2*WIDTH-1:WIDTH];
    assign res_lo   = fault_q ? p_lo : prod[WIDTH-1:0];
`endif

    // Faulted requests pass through FIX so done still lands one edge after acceptance.
    always_comb begin
        state_nx = state;
        if (accept) state_nx = fault_in ? FIX : RUN;
        else if (state == RUN) state_nx = cnt == CW'(WIDTH - 1) ? FIX : RUN;
        else if (state == FIX) state_nx = DONE;
        else if (state == DONE) state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state   <= IDLE;
            cnt     <= '0;
            m       <= '0;
            p_hi    <= '0;
            p_lo    <= '0;
            neg_q   <= 1'b0;
            fault_q <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            err     <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                cnt     <= '0;
                m       <= m_in;
                p_hi    <= hi_in;
                p_lo    <= lo_in;
                neg_q   <= a_neg ^ b_neg;
                fault_q <= fault_in;
            end else if (state == RUN) begin
                cnt  <= cnt + 1'b1;
                p_hi <= step_hi;
                p_lo <= step_lo;
            end else if (state == FIX) begin
                hi  <= res_hi;
                lo  <= res_lo;
                err <= fault_q;
            end
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed table, randomized ops against an arithmetic reference, and
// reset / start-while-busy / back-to-back sequences for muldiv_unit at WIDTH=32.
module tb_muldiv_unit;
    localparam int W = 32;

    logic         clk = 1'b0, clear = 1'b0, start = 1'b0, op_div = 1'b0, sign_en = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         busy, done, err;
    logic [W-1:0] hi, lo;
    int           checks = 0, failures = 0;

    typedef struct {
        string        name;
        logic         op, sgn;
        logic [W-1:0] x, y, eh, el;
        logic         ee;
    } vec_t;
    vec_t vecs[$];

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .clear(clear), .start(start), .op_div(op_div), .sign_en(sign_en),
        .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo), .err(err)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input string nm, input logic op, input logic sgn,
                                input logic [W-1:0] x, input logic [W-1:0] y,
                                input logic [W-1:0] eh, input logic [W-1:0] el, input logic ee);
        vec_t v;
        v.name = nm; v.op = op; v.sgn = sgn; v.x = x; v.y = y; v.eh = eh; v.el = el; v.ee = ee;
        vecs.push_back(v);
    endfunction

    // Reference: plain integer arithmetic on 64-bit values.
    function automatic void model(input logic op, input logic sgn, input logic [W-1:0] x,
                                  input logic [W-1:0] y, output logic [W-1:0] eh,
                                  output logic [W-1:0] el, output logic ee);
        logic signed [W-1:0] xs, ys;
        logic [2*W-1:0]      p;
        xs = x; ys = y;
        eh = '0; el = '0; ee = 1'b0;
        if (!op) begin
            p  = sgn ? 64'(longint'(xs) * longint'(ys)) : {{W{1'b0}}, x} * {{W{1'b0}}, y};
            eh = p[2*W-1:W];
            el = p[W-1:0];
        end
`ifdef MULDIV_DIV_EN
        else if (y == '0) begin
            eh = x; el = '1; ee = 1'b1;
        end else if (sgn) begin
            longint q, r;
            q  = longint'(xs) / longint'(ys);
            r  = longint'(xs) % longint'(ys);
            el = W'(q);
            eh = W'(r);
        end else begin
            el = x / y;
            eh = x % y;
        end
`else
        else ee = 1'b1;
`endif
    endfunction

    // Accept one op, scramble inputs while it runs, optionally poke start mid-flight.
    task automatic do_op(input string name, input logic op, input logic sgn,
                         input logic [W-1:0] x, input logic [W-1:0] y, input int poke,
                         output logic [W-1:0] rh, output logic [W-1:0] rl, output logic re);
        logic [W-1:0] eh, el, oh, ol;
        logic         ee;
        int           n, lat;
        bit           ok_busy, held;
        model(op, sgn, x, y, eh, el, ee);
        lat = ee ? 1 : W + 1;
        oh = hi; ol = lo;
        op_div = op; sign_en = sgn; a = x; b = y; start = 1'b1;
        tick;
        start = 1'b0;
        chk({name, " busy/done after accept"}, {62'b0, busy, done}, 64'b10);
        n = 0; ok_busy = 1'b1; held = 1'b1;
        while (!done && n < 100) begin
            op_div = 1'($urandom); sign_en = 1'($urandom); a = $urandom; b = $urandom;
            if (n == poke) start = 1'b1;
            if (!busy) ok_busy = 1'b0;
            if (hi !== oh || lo !== ol) held = 1'b0;
            tick;
            start = 1'b0;
            n++;
        end
        chk({name, " latency"}, 64'(n), 64'(lat));
        chk({name, " busy throughout"}, 64'(ok_busy), 64'd1);
        chk({name, " outputs held while busy"}, 64'(held), 64'd1);
        chk({name, " hi"}, 64'(hi), 64'(eh));
        chk({name, " lo"}, 64'(lo), 64'(el));
        chk({name, " err"}, 64'(err), 64'(ee));
        chk({name, " busy low in done"}, 64'(busy), 64'd0);
        rh = hi; rl = lo; re = err;
    endtask

    initial begin
        logic [W-1:0] rh, rl, x, y;
        logic         re;
        int           pulses;

        add("smul -3*7",        1'b0, 1'b1, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
        add("umul max*max",     1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
        add("smul min*min",     1'b0, 1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0);
        add("umul 0*x",         1'b0, 1'b0, 32'h00000000, 32'h00012345, 32'h00000000, 32'h00000000, 1'b0);
`ifdef MULDIV_DIV_EN
        add("sdiv -7/2",        1'b1, 1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        add("sdiv min/-1",      1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
        add("div 5/0",          1'b1, 1'b0, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1);
        add("udiv 100/7",       1'b1, 1'b0, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0);
        add("sdiv 7/-2",        1'b1, 1'b1, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0);
`else
        add("sdiv -7/2 nodiv",  1'b1, 1'b1, 32'hFFFFFFF9, 32'd2,        32'd0,        32'd0,        1'b1);
        add("div 5/0 nodiv",    1'b1, 1'b0, 32'd5,        32'd0,        32'd0,        32'd0,        1'b1);
`endif

        #2;
        chk("reset busy/done", {62'b0, busy, done}, 64'd0);
        chk("reset hi/lo", {hi, lo}, 64'd0);
        chk("reset err", 64'(err), 64'd0);
        #10 clear = 1'b1;

        // Consecutive entries are issued back-to-back from DONE; the first has start poked mid-run.
        foreach (vecs[i]) begin
            do_op(vecs[i].name, vecs[i].op, vecs[i].sgn, vecs[i].x, vecs[i].y, (i == 0) ? 5 : -1, rh, rl, re);
            chk({vecs[i].name, " table hi"}, 64'(rh), 64'(vecs[i].eh));
            chk({vecs[i].name, " table lo"}, 64'(rl), 64'(vecs[i].el));
            chk({vecs[i].name, " table err"}, 64'(re), 64'(vecs[i].ee));
        end
        tick;
        chk("idle after done", {62'b0, busy, done}, 64'd0);
        chk("result held in idle", {hi, lo}, {vecs[vecs.size()-1].eh, vecs[vecs.size()-1].el});

        for (int i = 0; i < 60; i++) begin
            x = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            y = ($urandom_range(0, 7) == 0) ? 32'h0 : ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom;
            do_op("rand", 1'($urandom), 1'($urandom), x, y, $urandom_range(0, 40), rh, rl, re);
            repeat ($urandom_range(0, 2)) tick;
        end

        op_div = 1'b0; sign_en = 1'b0; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; start = 1'b1;
        tick;
        start = 1'b0;
        repeat (10) tick;
        #2 clear = 1'b0;
        #1;
        chk("async reset busy/done", {62'b0, busy, done}, 64'd0);
        chk("async reset hi/lo", {hi, lo}, 64'd0);
        chk("async reset err", 64'(err), 64'd0);
        #2 clear = 1'b1;
        pulses = 0;
        repeat (40) begin
            tick;
            if (done || busy) pulses++;
        end
        chk("no activity after abandoned op", 64'(pulses), 64'd0);
        do_op("after reset", 1'b0, 1'b1, 32'hFFFFFFFD, 32'd7, -1, rh, rl, re);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
